// File: rtl/iq_writer_pkg.sv
// rtl/iq_writer_pkg.sv - shared state type, sizes and quantize(); IQ_SAT_EN selects saturation
package iq_writer_pkg;

    localparam int SAMPLE_WIDTH   = 16;
    localparam int BYTES_PER_PAIR = 4;

    typedef enum logic [2:0] {
        S_I_LO,
        S_I_HI,
        S_Q_LO,
        S_Q_HI,
        S_WRITE
    } state_t;

    // Result is returned 64 bits wide and already limited to data_width signed range,
    // so callers only need to take the low data_width bits.
    function automatic logic signed [63:0] quantize(
        input logic [SAMPLE_WIDTH-1:0] sample,
        input int                      quant_bits,
        input int                      data_width
    );
        logic signed [63:0] v;
`ifdef IQ_SAT_EN
        logic signed [63:0] lim;
`endif
        v = {{(64-SAMPLE_WIDTH){sample[SAMPLE_WIDTH-1]}}, sample};
        v = v <<< quant_bits;
`ifdef IQ_SAT_EN
        lim = 64'sd1 <<< (data_width - 1);
        if (v > lim - 64'sd1) begin
            v = lim - 64'sd1;
        end else if (v < -lim) begin
            v = -lim;
        end
`else
        v = (v <<< (64 - data_width)) >>> (64 - data_width);
`endif
        return v;
    endfunction

endpackage

// File: rtl/iq_quantizer.sv
// rtl/iq_quantizer.sv - combinational shift with wrap, or saturation when IQ_SAT_EN is defined
module iq_quantizer
    import iq_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int QUANT_BITS = 0
) (
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0]   quant
);

    assign quant = DATA_WIDTH'(quantize(sample, QUANT_BITS, DATA_WIDTH));

endmodule

// File: rtl/iq_sample_writer.sv
// rtl/iq_sample_writer.sv - byte FIFO to lockstep I/Q sample FIFO writer; IQ_SAT_EN enables saturation
module iq_sample_writer #(
    parameter int DATA_WIDTH   = 16,
    parameter int SAMPLE_WIDTH = 16,
    parameter int QUANT_BITS   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    input  logic                  I_full,
    input  logic                  Q_full,
    output logic                  I_wr_en,
    output logic                  Q_wr_en,
    output logic [DATA_WIDTH-1:0] I_dout,
    output logic [DATA_WIDTH-1:0] Q_dout,
    output logic [31:0]           sample_count
);

    import iq_writer_pkg::state_t;
    import iq_writer_pkg::S_I_LO;
    import iq_writer_pkg::S_I_HI;
    import iq_writer_pkg::S_Q_LO;
    import iq_writer_pkg::S_Q_HI;
    import iq_writer_pkg::S_WRITE;

    state_t                  state;
    logic [7:0]              i_lo;
    logic [7:0]              i_hi;
    logic [7:0]              q_lo;
    logic [SAMPLE_WIDTH-1:0] i_sample;
    logic [SAMPLE_WIDTH-1:0] q_sample;
    logic [DATA_WIDTH-1:0]   i_quant;
    logic [DATA_WIDTH-1:0]   q_quant;

    // Q_hi is taken straight from the FIFO head so the pair is registered on its pop.
    assign i_sample = {i_hi, i_lo};
    assign q_sample = {in_dout, q_lo};

    // Gating with reset keeps the strobes low while reset is held.
    assign in_rd_en = reset && (state != S_WRITE) && !in_empty;
    assign I_wr_en  = reset && (state == S_WRITE) && !I_full && !Q_full;
    assign Q_wr_en  = I_wr_en;

    iq_quantizer #(
        .DATA_WIDTH (DATA_WIDTH),
        .QUANT_BITS (QUANT_BITS)
    ) u_quant_i (
        .sample (i_sample),
        .quant  (i_quant)
    );

    iq_quantizer #(
        .DATA_WIDTH (DATA_WIDTH),
        .QUANT_BITS (QUANT_BITS)
    ) u_quant_q (
        .sample (q_sample),
        .quant  (q_quant)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_I_LO;
            i_lo         <= '0;
            i_hi         <= '0;
            q_lo         <= '0;
            I_dout       <= '0;
            Q_dout       <= '0;
            sample_count <= '0;
        end else begin
            case (state)
                S_I_LO: begin
                    if (in_rd_en) begin
                        i_lo  <= in_dout;
                        state <= S_I_HI;
                    end
                end
                S_I_HI: begin
                    if (in_rd_en) begin
                        i_hi  <= in_dout;
                        state <= S_Q_LO;
                    end
                end
                S_Q_LO: begin
                    if (in_rd_en) begin
                        q_lo  <= in_dout;
                        state <= S_Q_HI;
                    end
                end
                S_Q_HI: begin
                    if (in_rd_en) begin
                        I_dout <= i_quant;
                        Q_dout <= q_quant;
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Both FIFOs must have room, otherwise the pair waits with data held.
                    if (I_wr_en) begin
                        sample_count <= sample_count + 32'd1;
                        state        <= S_I_LO;
                    end
                end
                default: state <= S_I_LO;
            endcase
        end
    end

endmodule
